// File: rtl/bounce_sound.sv
// Piezo sound effects for paddle, wall and score events in the pong game.
// Optional feature macro BOUNCE_SOUND_SCORE_JINGLE_EN adds the two-note score jingle.
module bounce_sound #(
    parameter int HALF_PADDLE   = 11364,
    parameter int HALF_WALL     = 22727,
    parameter int HALF_SCORE_HI = 6818,
    parameter int HALF_SCORE_LO = 13636,
    parameter int NOTE_LEN      = 1200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] bounce,
    input  logic       score_event,
    output logic       buzzer,
    output logic       busy
);

`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
    typedef enum logic [1:0] {IDLE, TONE, SCORE_HI, SCORE_LO} state_t;
`else
    typedef enum logic [1:0] {IDLE, TONE} state_t;
`endif

    typedef enum logic [1:0] {PRI_NONE, PRI_WALL, PRI_PADDLE, PRI_SCORE} pri_t;

    localparam logic [15:0] PADDLE_LIM = 16'(HALF_PADDLE - 1);
    localparam logic [15:0] WALL_LIM   = 16'(HALF_WALL - 1);
    localparam logic [20:0] DUR_LIM    = 21'(NOTE_LEN - 1);
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
    localparam logic [15:0] SCORE_HI_LIM = 16'(HALF_SCORE_HI - 1);
    localparam logic [15:0] SCORE_LO_LIM = 16'(HALF_SCORE_LO - 1);
`endif

    state_t      state;
    logic [15:0] half_cnt;
    logic [20:0] dur_cnt;
    logic [1:0]  bounce_q;
    logic        primed;       // low for the first clk after reset so held inputs are not edges
    logic        tone_paddle;  // TONE is playing the paddle pitch rather than the wall pitch

    logic        bounce_chg;
    logic        paddle_ev;
    logic        wall_ev;
    logic        score_ev;
    pri_t        ev_pri;
    pri_t        cur_pri;
    logic        start;
    logic [15:0] half_lim;
    logic        half_end;
    logic        dur_end;

    assign bounce_chg = primed && enable && (bounce != bounce_q);
    assign paddle_ev  = bounce_chg && (bounce == 2'd1 || bounce == 2'd2);
    assign wall_ev    = bounce_chg && (bounce == 2'd3);

`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
    logic score_q;
    assign score_ev = primed && enable && score_event && !score_q;
`else
    logic unused_score;
    assign score_ev     = 1'b0;
    assign unused_score = ^{score_event, 16'(HALF_SCORE_HI), 16'(HALF_SCORE_LO)};
`endif

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ev_pri = PRI_NONE;
        if (score_ev)       ev_pri = PRI_SCORE;
        else if (paddle_ev) ev_pri = PRI_PADDLE;
        else if (wall_ev)   ev_pri = PRI_WALL;
    end

    always_comb begin
        cur_pri  = PRI_NONE;
        half_lim = PADDLE_LIM;
        case (state)
            TONE: begin
                cur_pri  = tone_paddle ? PRI_PADDLE : PRI_WALL;
                half_lim = tone_paddle ? PADDLE_LIM : WALL_LIM;
            end
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
            SCORE_HI: begin
                cur_pri  = PRI_SCORE;
                half_lim = SCORE_HI_LIM;
            end
            SCORE_LO: begin
                cur_pri  = PRI_SCORE;
                half_lim = SCORE_LO_LIM;
            end
`endif
            default: ;
        endcase
    end

    // Equal or higher priority restarts the note; lower priority is dropped.
    assign start    = (ev_pri != PRI_NONE) && (ev_pri >= cur_pri);
    assign half_end = (half_cnt == half_lim);
    assign dur_end  = (dur_cnt == DUR_LIM);

    // NOTE: sequential state uses non-blocking assignments and the asynchronous reset
    // clears every register, so the first clk after release starts from a known state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            buzzer      <= 1'b0;
            busy        <= 1'b0;
            half_cnt    <= '0;
            dur_cnt     <= '0;
            bounce_q    <= '0;
            primed      <= 1'b0;
            tone_paddle <= 1'b0;
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
            score_q     <= 1'b0;
`endif
        end else begin
            bounce_q <= bounce;
            primed   <= 1'b1;
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
            score_q  <= score_event;
`endif
            if (!enable) begin
                state    <= IDLE;
                buzzer   <= 1'b0;
                busy     <= 1'b0;
                half_cnt <= '0;
                dur_cnt  <= '0;
            end else if (start) begin
                half_cnt <= '0;
                dur_cnt  <= '0;
                buzzer   <= 1'b1;
                busy     <= 1'b1;
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
                if (ev_pri == PRI_SCORE) begin
                    state <= SCORE_HI;
                end else
`endif
                begin
                    state       <= TONE;
                    tone_paddle <= (ev_pri == PRI_PADDLE);
                end
            end else if (state != IDLE) begin
                if (dur_end) begin
                    half_cnt <= '0;
                    dur_cnt  <= '0;
                    case (state)
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
                        SCORE_HI: begin
                            state  <= SCORE_LO;
                            buzzer <= 1'b1;
                        end
`endif
                        default: begin
                            state  <= IDLE;
                            buzzer <= 1'b0;
                            busy   <= 1'b0;
                        end
                    endcase
                end else begin
                    dur_cnt <= dur_cnt + 21'd1;
                    if (half_end) begin
                        half_cnt <= '0;
                        buzzer   <= ~buzzer;
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bounce_sound.sv
// Scoreboard bench for bounce_sound: stimulus queues the expected {busy,buzzer} per clk,
// a negedge monitor pops and compares. Covers the jingle build when the macro is defined.
`timescale 1ns/1ps
module tb_bounce_sound;

    localparam int NL  = 40;
    localparam int HP  = 4;
    localparam int HW  = 8;
    localparam int HSH = 2;
    localparam int HSL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] bounce = 2'd0;
    logic       score_event = 1'b0;
    logic       buzzer;
    logic       busy;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned tag;
        logic [1:0]  exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bounce_sound #(
        .HALF_PADDLE(HP), .HALF_WALL(HW), .HALF_SCORE_HI(HSH),
        .HALF_SCORE_LO(HSL), .NOTE_LEN(NL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bounce(bounce),
        .score_event(score_event), .buzzer(buzzer), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (busy*2+buzzer)", name, act, exp);
        end
    endtask

    // Expected {busy,buzzer} r clks after a note started (r=0 is the start edge).
    function automatic logic [1:0] note(input int r, input int h);
        if (r < 0 || r >= NL) return 2'b00;
        return {1'b1, ((r / h) % 2) == 0};
    endfunction

    function automatic logic [1:0] jingle(input int r);
        if (r < NL) return note(r, HSH);
        return note(r - NL, HSL);
    endfunction

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input logic [1:0] b, input logic s, input logic en, input logic rs,
                        input logic [1:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        #1;
        bounce      = b;
        score_event = s;
        enable      = en;
        reset       = rs;
        e.tag  = cyc + 1;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b1, 1'b0, 2'b00, "idle");
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].tag <= cyc) begin
            mon_e = sb.pop_front();
            check(mon_e.name, int'({busy, buzzer}), int'(mon_e.exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ex;
        for (int i = 0; i < 3; i++) step(2'd0, 1'b0, 1'b1, 1'b1, 2'b00, "reset");
        idle(4);

        // Single paddle note
        for (int i = 0; i < 45; i++)
            step(2'd1, 1'b0, 1'b1, 1'b0, note(i, HP), $sformatf("paddle[%0d]", i));
        idle(3);

        // Wall note preempted by paddle at clk 10
        for (int i = 0; i < 55; i++)
            step((i < 10) ? 2'd3 : 2'd1, 1'b0, 1'b1, 1'b0,
                 (i < 10) ? note(i, HW) : note(i - 10, HP), $sformatf("wall_paddle[%0d]", i));
        idle(3);

        // Wall event during a paddle note is dropped
        for (int i = 0; i < 46; i++)
            step((i < 10) ? 2'd2 : 2'd3, 1'b0, 1'b1, 1'b0, note(i, HP),
                 $sformatf("paddle_wall[%0d]", i));
        idle(3);

        // Score event alone
        for (int i = 0; i < 85; i++) begin
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
            ex = jingle(i);
`else
            ex = 2'b00;
`endif
            step(2'd0, i < 5, 1'b1, 1'b0, ex, $sformatf("score[%0d]", i));
        end
        idle(3);

        // Simultaneous paddle+score, then another paddle at clk 8
        for (int i = 0; i < 90; i++) begin
`ifdef BOUNCE_SOUND_SCORE_JINGLE_EN
            ex = jingle(i);
`else
            ex = (i < 8) ? note(i, HP) : note(i - 8, HP);
`endif
            step((i < 8) ? 2'd1 : 2'd2, i < 3, 1'b1, 1'b0, ex, $sformatf("simul[%0d]", i));
        end
        idle(3);

        // Equal-priority paddle restarts the note
        for (int i = 0; i < 60; i++)
            step((i < 12) ? 2'd1 : 2'd2, 1'b0, 1'b1, 1'b0,
                 (i < 12) ? note(i, HP) : note(i - 12, HP), $sformatf("restart[%0d]", i));
        idle(3);

        // Enable dropped at clk 15, bounce changes ignored while disabled
        for (int i = 0; i < 15; i++)
            step(2'd2, 1'b0, 1'b1, 1'b0, note(i, HP), $sformatf("pre_disable[%0d]", i));
        for (int i = 0; i < 10; i++)
            step((i % 2 == 1) ? 2'd1 : 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, $sformatf("disabled[%0d]", i));
        for (int i = 0; i < 4; i++)
            step(2'd1, 1'b0, 1'b1, 1'b0, 2'b00, $sformatf("reenable[%0d]", i));
        idle(3);

        // Reset at clk 20 with bounce held at 2 through release
        for (int i = 0; i < 20; i++)
            step(2'd2, 1'b0, 1'b1, 1'b0, note(i, HP), $sformatf("pre_reset[%0d]", i));
        step(2'd2, 1'b0, 1'b1, 1'b1, 2'b00, "reset_mid");
        #1;
        check("reset_async", int'({busy, buzzer}), 0);
        step(2'd2, 1'b0, 1'b1, 1'b1, 2'b00, "reset_hold");
        step(2'd2, 1'b0, 1'b1, 1'b1, 2'b00, "reset_hold");
        for (int i = 0; i < 10; i++)
            step(2'd2, 1'b0, 1'b1, 1'b0, 2'b00, $sformatf("post_reset_hold[%0d]", i));
        for (int i = 0; i < 45; i++)
            step(2'd1, 1'b0, 1'b1, 1'b0, note(i, HP), $sformatf("post_reset_paddle[%0d]", i));
        idle(3);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
